// File: rtl/fetch_ctrl.sv
`default_nettype none
// ---- fetch_ctrl : IF-stage stall/flush/redirect control with halt drain and perf counters ----
// ---- Revision 1.0 ----
module fetch_ctrl #(
    parameter int PC_W       = 16,
    parameter int HALT_DRAIN = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            hlt,
    input  logic            load_use,
    input  logic            dmem_busy,
    input  logic            Call,
    input  logic            Branch,
    input  logic            Ret,
    input  logic [PC_W-1:0] PCcall,
    input  logic [PC_W-1:0] PCbranch,
    input  logic [PC_W-1:0] PCret,
    output logic            stall_IF,
    output logic            stall_ID,
    output logic            stall_all,
    output logic            flush_IF_ID,
    output logic            flush_ID_EX,
    output logic            flush_EX_MEM,
    output logic            redir_valid,
    output logic [PC_W-1:0] redir_pc,
    output logic            halted,
    output logic [15:0]     redir_cnt,
    output logic [15:0]     wait_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [2:0]  DRAIN_INIT = 3'(HALT_DRAIN);
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    state_t      state_q, state_d;
    logic [2:0]  drain_q, drain_d;
    logic [15:0] redir_cnt_q, redir_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        any_redir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            drain_q     <= 3'd0;
            redir_cnt_q <= 16'd0;
            wait_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            redir_cnt_q <= redir_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        drain_d      = drain_q;
        redir_cnt_d  = redir_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        stall_IF     = 1'b0;
        stall_ID     = 1'b0;
        stall_all    = dmem_busy;
        flush_IF_ID  = 1'b0;
        flush_ID_EX  = 1'b0;
        flush_EX_MEM = 1'b0;
        redir_valid  = 1'b0;
        redir_pc     = '0;
        halted       = (state_q == HALTED);
        any_redir    = (Ret | Call | Branch) && (state_q != HALTED);

        if (!dmem_busy) begin
            if (any_redir) begin
                // Older control flow wins over anything younger, including a pending halt
                redir_valid = 1'b1;
                flush_IF_ID = 1'b1;
                flush_ID_EX = 1'b1;
                if (Ret) begin
                    redir_pc     = PCret;
                    flush_EX_MEM = 1'b1;
                end else if (Call) begin
                    redir_pc = PCcall;
                end else begin
                    redir_pc = PCbranch;
                end
                state_d = RUN;
                drain_d = 3'd0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (load_use) begin
                            stall_IF    = 1'b1;
                            stall_ID    = 1'b1;
                            flush_ID_EX = 1'b1;
                        end else if (hlt) begin
                            stall_IF    = 1'b1;
                            flush_IF_ID = 1'b1;
                            drain_d     = DRAIN_INIT;
                            state_d     = DRAIN;
                        end
                    end
                    DRAIN: begin
                        stall_IF    = 1'b1;
                        flush_IF_ID = 1'b1;
                        drain_d     = drain_q - 3'd1;
                        if (drain_q == 3'd1) begin
                            state_d = HALTED;
                        end
                    end
                    HALTED: begin
                        stall_IF    = 1'b1;
                        flush_IF_ID = 1'b1;
                    end
                    default: begin
                        state_d = RUN;
                        drain_d = 3'd0;
                    end
                endcase
            end

            if (redir_valid && (redir_cnt_q != CNT_MAX)) begin
                redir_cnt_d = redir_cnt_q + 16'd1;
            end
        end else if ((state_q != HALTED) && (wait_cnt_q != CNT_MAX)) begin
            wait_cnt_d = wait_cnt_q + 16'd1;
        end
    end

    assign redir_cnt = redir_cnt_q;
    assign wait_cnt  = wait_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ---- tb_fetch_ctrl : randomized + directed scoreboard bench for fetch_ctrl ----
// ---- Revision 1.0 ----
module tb_fetch_ctrl;
    localparam int PC_W       = 16;
    localparam int HALT_DRAIN = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            hlt = 1'b0, load_use = 1'b0, dmem_busy = 1'b0;
    logic            Call = 1'b0, Branch = 1'b0, Ret = 1'b0;
    logic [PC_W-1:0] PCcall = '0, PCbranch = '0, PCret = '0;
    logic            stall_IF, stall_ID, stall_all;
    logic            flush_IF_ID, flush_ID_EX, flush_EX_MEM;
    logic            redir_valid, halted;
    logic [PC_W-1:0] redir_pc;
    logic [15:0]     redir_cnt, wait_cnt;

    fetch_ctrl #(.PC_W(PC_W), .HALT_DRAIN(HALT_DRAIN)) dut (
        .clk(clk), .rst(rst), .hlt(hlt), .load_use(load_use), .dmem_busy(dmem_busy),
        .Call(Call), .Branch(Branch), .Ret(Ret),
        .PCcall(PCcall), .PCbranch(PCbranch), .PCret(PCret),
        .stall_IF(stall_IF), .stall_ID(stall_ID), .stall_all(stall_all),
        .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX), .flush_EX_MEM(flush_EX_MEM),
        .redir_valid(redir_valid), .redir_pc(redir_pc), .halted(halted),
        .redir_cnt(redir_cnt), .wait_cnt(wait_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  ctrl;   // {stall_IF, stall_ID, stall_all, flush_IF_ID, flush_ID_EX, flush_EX_MEM}
        logic        rv;
        logic [15:0] rpc;
        logic        hl;
        logic [15:0] rc;
        logic [15:0] wc;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 1'b0;

    // Reference model: "halt requested, N older instructions still to retire" plus counters
    bit          m_halted;
    int          m_drain_left;
    int unsigned m_rc, m_wc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r_n, input bit ret, input bit call, input bit br,
                        input bit lu, input bit h, input bit busy,
                        input logic [15:0] pr, input logic [15:0] pc, input logic [15:0] pb);
        exp_t e;
        bit   redirect;
        @(posedge clk);
        #1;
        rst = r_n; Ret = ret; Call = call; Branch = br; load_use = lu; hlt = h;
        dmem_busy = busy; PCret = pr; PCcall = pc; PCbranch = pb;

        if (!r_n) begin
            m_halted = 1'b0; m_drain_left = 0; m_rc = 0; m_wc = 0;
        end

        e.ctrl = 6'b0; e.rv = 1'b0; e.rpc = 16'h0;
        e.hl = m_halted; e.rc = 16'(m_rc); e.wc = 16'(m_wc);
        e.ctrl[3] = busy;
        redirect = !busy && !m_halted && (ret || call || br);

        if (!busy) begin
            if (redirect) begin
                e.rv = 1'b1;
                e.rpc = ret ? pr : (call ? pc : pb);
                e.ctrl[2] = 1'b1; e.ctrl[1] = 1'b1; e.ctrl[0] = ret;
            end else if (m_halted || m_drain_left > 0) begin
                e.ctrl[5] = 1'b1; e.ctrl[2] = 1'b1;
            end else if (lu) begin
                e.ctrl[5] = 1'b1; e.ctrl[4] = 1'b1; e.ctrl[1] = 1'b1;
            end else if (h) begin
                e.ctrl[5] = 1'b1; e.ctrl[2] = 1'b1;
            end
        end
        q.push_back(e);

        if (r_n && !busy) begin
            if (redirect) begin
                m_drain_left = 0;
                if (m_rc < 32'hFFFF) m_rc++;
            end else if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) m_halted = 1'b1;
            end else if (!m_halted && !lu && h) begin
                m_drain_left = HALT_DRAIN;
            end
        end else if (r_n && busy && !m_halted) begin
            if (m_wc < 32'hFFFF) m_wc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
    endtask

    // Monitor: outputs are valid every cycle; sample mid-cycle on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ctrl",        {26'b0, stall_IF, stall_ID, stall_all, flush_IF_ID, flush_ID_EX, flush_EX_MEM}, {26'b0, e.ctrl});
                chk("redir_valid", {31'b0, redir_valid}, {31'b0, e.rv});
                chk("redir_pc",    {16'b0, redir_pc},    {16'b0, e.rpc});
                chk("halted",      {31'b0, halted},      {31'b0, e.hl});
                chk("redir_cnt",   {16'b0, redir_cnt},   {16'b0, e.rc});
                chk("wait_cnt",    {16'b0, wait_cnt},    {16'b0, e.wc});
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        m_halted = 1'b0; m_drain_left = 0; m_rc = 0; m_wc = 0;
        step(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        step(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        idle(2);

        // Ret beats Branch
        step(1, 1, 0, 1, 0, 0, 0, 16'h0040, 16'h1234, 16'h0100);
        idle(1);
        // Single-cycle load-use, then load-use under a branch
        step(1, 0, 0, 0, 1, 0, 0, 16'h0, 16'h0, 16'h0);
        idle(1);
        step(1, 0, 0, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0abc);
        idle(1);

        // Halt, drain, halted; branch afterwards ignored
        step(1, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0);
        idle(6);
        step(1, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0300);
        idle(1);

        // Reset out of HALTED, then halt cancelled by a branch in the 2nd drain cycle
        step(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        idle(1);
        step(1, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0);
        idle(1);
        step(1, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0200);
        idle(5);

        // Memory freeze holding a call
        for (int i = 0; i < 5; i++) step(1, 0, 1, 0, 0, 0, 1, 16'h0, 16'h0777, 16'h0);
        step(1, 0, 1, 0, 0, 0, 0, 16'h0, 16'h0777, 16'h0);
        idle(1);

        // Reach HALTED, then asynchronous reset mid-cycle
        step(1, 0, 0, 0, 0, 1, 0, 16'h0, 16'h0, 16'h0);
        idle(5);
        step(1, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0);
        step(0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
        idle(1);

        // Saturate redir_cnt
        for (int i = 0; i < 65540; i++) step(1, 0, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'(i));
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                 16'($urandom), 16'($urandom), 16'($urandom));
        end
        idle(2);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain_queue actual=%0d expected=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: PC_W, 16, program-counter width.
REQ-002 Parameter: HALT_DRAIN, 3, cycles that older instructions drain after a halt is decoded; legal range 1..7.
REQ-003 Port: clk  in  1  single clock, all state updates on posedge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: hlt  in  1  halt instruction valid in ID.
REQ-006 Port: load_use  in  1  load-use hazard detected in ID.
REQ-007 Port: dmem_busy  in  1  data memory is multicycle busy; the whole pipeline freezes.
REQ-008 Port: Call, Branch  in  1 each  call, or taken branch, resolved in EX.
REQ-009 Port: Ret  in  1  return resolved in MEM.
REQ-010 Port: PCcall, PCbranch, PCret  in  PC_W each  redirect targets.
REQ-011 Port: stall_IF, stall_ID, stall_all  out  1 each  hold PC, hold IF/ID, freeze all pipeline registers.
REQ-012 Port: flush_IF_ID, flush_ID_EX, flush_EX_MEM  out  1 each  convert the stage register to a bubble.
REQ-013 Port: redir_valid  out  1, redir_pc  out  PC_W  PC load request and target for IF.
REQ-014 Port: halted  out  1  processor halted.
REQ-015 Port: redir_cnt, wait_cnt  out  16 each  saturating performance counters.

Function
REQ-016 The block SHALL implement state machine states RUN, DRAIN, HALTED in registered state; all stall, flush, and redirect outputs SHALL be combinational from state, drain count, and inputs.
REQ-017 stall_all SHALL equal dmem_busy in every state; while stall_all=1, all other stall, flush, and redir outputs SHALL be 0, and state, drain count, and redir_cnt SHALL hold.
REQ-018 Redirect priority, evaluated only when dmem_busy=0, SHALL be: Ret > Call > Branch.
REQ-019 On a Ret redirect: redir_valid=1, redir_pc=PCret, flush_IF_ID=flush_ID_EX=flush_EX_MEM=1.
REQ-020 On a Call or Branch redirect: redir_valid=1, redir_pc=PCcall or PCbranch, flush_IF_ID=flush_ID_EX=1, flush_EX_MEM=0.
REQ-021 When redir_valid=0, redir_pc SHALL be 0.
REQ-022 RUN with no redirect and load_use=1: stall_IF=stall_ID=flush_ID_EX=1 for that cycle only; state stays RUN.
REQ-023 RUN with no redirect and hlt=1: stall_IF=1, flush_IF_ID=1, load drain count with HALT_DRAIN, go to DRAIN.
REQ-024 A redirect in the same cycle as load_use or hlt SHALL win: load_use and hlt are ignored (younger, flushed).
REQ-025 DRAIN: stall_IF=1 and flush_IF_ID=1 every cycle; drain count decrements by 1 per non-frozen cycle; when the count is 1 and decrements, go to HALTED.
REQ-026 DRAIN with a redirect (older control-flow instruction): issue the redirect per REQ-018..020, clear the drain count, return to RUN; the halt is cancelled.
REQ-027 HALTED: halted=1, stall_IF=1, flush_IF_ID=1; redirect inputs are ignored; the block exits only on reset.
REQ-028 halted SHALL be 0 in RUN and DRAIN.
REQ-029 redir_cnt SHALL increment on each cycle with redir_valid=1 and saturate at 16'hFFFF.
REQ-030 wait_cnt SHALL increment on each cycle with dmem_busy=1 in RUN or DRAIN and saturate at 16'hFFFF; it SHALL NOT count in HALTED.

Reset
REQ-031 rst=0 SHALL asynchronously force state=RUN, drain count=0, redir_cnt=0, and wait_cnt=0; combinational outputs follow, so all stall, flush, redir, and halted outputs are 0 when other inputs are 0.
REQ-032 Reset asserted mid-DRAIN or in HALTED SHALL return to RUN with the halt cancelled.
REQ-033 The first posedge after rst returns to 1 SHALL perform normal RUN evaluation.

Verification
REQ-034 Ret=1, Branch=1, PCret=16'h0040, PCbranch=16'h0100 in RUN -> redir_pc=16'h0040; all three flushes=1; redir_cnt +1.
REQ-035 Case A: load_use=1 for 1 cycle -> stall_IF=stall_ID=flush_ID_EX=1 for exactly 1 cycle. Case B: load_use=1 with Branch=1 -> redirect only, stall_IF=0.
REQ-036 hlt=1 in RUN with HALT_DRAIN=3 -> DRAIN for 3 cycles, then halted=1 on the 4th cycle and it stays 1; a later Branch=1 -> no redir_valid.
REQ-037 hlt, then Branch=1 (PCbranch=16'h0200) in the 2nd DRAIN cycle -> redir_valid=1, redir_pc=16'h0200, state RUN, halted never asserts.
REQ-038 dmem_busy=1 for 5 cycles with Call=1 held -> stall_all=1 and no redirect for 5 cycles, wait_cnt=5; the redirect to PCcall issues on the first cycle after dmem_busy falls.
REQ-039 Reset in HALTED, plus saturation check -> halted=0 asynchronously and counters=0; forcing 65536 redirects -> redir_cnt stays 16'hFFFF.
